exc_pipe_ctrl: RTL and testbench

EXC_PIPE_CTRL -- requirements
Module: exc_pipe_ctrl

---
 rtl/exc_pipe_ctrl.sv | 138 +++++++++++++
 tb/tb_exc_pipe_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/exc_pipe_ctrl.sv
// Exception-merging pipeline stage with a CP0 request/acknowledge handshake.
// Optional taken-exception counter enabled by defining EXC_PIPE_CNT_EN.
module exc_pipe_ctrl #(
  parameter int NSRC   = 4,
  parameter int CODE_W = 5,
  parameter int PC_W   = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     valid_in,
  input  logic [PC_W-1:0]          pc_in,
  input  logic [31:0]              cause_in,
  input  logic                     exc_in,
  input  logic [NSRC-1:0]          src_req,
  input  logic [NSRC*CODE_W-1:0]   src_code,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     exc_ack,
  output logic                     valid_out,
  output logic [PC_W-1:0]          pc_out,
  output logic [31:0]              cause_out,
  output logic                     exc_req,
  output logic                     busy,
  output logic [15:0]              exc_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [31:0]       r_cause;
  logic              r_exc_req;
  logic              r_busy;

  logic [CODE_W-1:0] w_code;
  logic              w_exc;
  logic [31:0]       w_cause;
  logic              w_ack_take;
  logic              w_unused_cause;

  // Oldest exception wins; otherwise lowest-index local source.
  always_comb begin
    w_code = cause_in[CODE_W+1:2];
    if (!exc_in) begin
      w_code = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (src_req[i]) w_code = src_code[i*CODE_W +: CODE_W];
      end
    end
  end

  assign w_exc          = valid_in & (exc_in | (|src_req));
  assign w_ack_take     = (r_state == REQ) & exc_ack;
  assign w_unused_cause = ^cause_in[30:0];

  always_comb begin
    w_cause    = '0;
    w_cause[31] = cause_in[31];
    if (w_exc) w_cause[CODE_W+1:2] = w_code;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_cause   <= '0;
      r_exc_req <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (flush) begin
            r_valid       <= 1'b0;
            r_cause[30:0] <= '0;
          end else if (!stall) begin
            r_valid <= valid_in;
            r_pc    <= pc_in;
            r_cause <= w_cause;
            if (w_exc) begin
              r_state   <= REQ;
              r_exc_req <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
        end
        REQ: begin
          if (exc_ack) begin
            r_valid       <= 1'b0;
            r_cause[30:0] <= '0;
            r_state       <= DRAIN;
            r_exc_req     <= 1'b0;
          end
        end
        DRAIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_exc_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign valid_out = r_valid;
  assign pc_out    = r_pc;
  assign cause_out = r_cause;
  assign exc_req   = r_exc_req;
  assign busy      = r_busy;

`ifdef EXC_PIPE_CNT_EN
  logic [15:0] r_exc_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exc_cnt <= '0;
    end else if (w_ack_take && (r_exc_cnt != 16'hFFFF)) begin
      r_exc_cnt <= r_exc_cnt + 16'd1;
    end
  end

  assign exc_cnt = r_exc_cnt;
`else
  logic w_unused_ack;

  assign w_unused_ack = w_ack_take;
  assign exc_cnt      = 16'h0000;
`endif

endmodule

// File: tb/tb_exc_pipe_ctrl.sv
// Directed bench for exc_pipe_ctrl: merge priority, handshake, flush/stall, reset.
// Counter checks adapt to whether EXC_PIPE_CNT_EN is defined.
module tb_exc_pipe_ctrl;

  localparam int NSRC   = 4;
  localparam int CODE_W = 5;
  localparam int PC_W   = 32;

  logic                   clk;
  logic                   reset_n;
  logic                   valid_in;
  logic [PC_W-1:0]        pc_in;
  logic [31:0]            cause_in;
  logic                   exc_in;
  logic [NSRC-1:0]        src_req;
  logic [NSRC*CODE_W-1:0] src_code;
  logic                   stall;
  logic                   flush;
  logic                   exc_ack;
  logic                   valid_out;
  logic [PC_W-1:0]        pc_out;
  logic [31:0]            cause_out;
  logic                   exc_req;
  logic                   busy;
  logic [15:0]            exc_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int n_acks   = 0;

  exc_pipe_ctrl #(.NSRC(NSRC), .CODE_W(CODE_W), .PC_W(PC_W)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .pc_in(pc_in),
    .cause_in(cause_in), .exc_in(exc_in), .src_req(src_req), .src_code(src_code),
    .stall(stall), .flush(flush), .exc_ack(exc_ack), .valid_out(valid_out),
    .pc_out(pc_out), .cause_out(cause_out), .exc_req(exc_req), .busy(busy),
    .exc_cnt(exc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_cnt(input int acks);
`ifdef EXC_PIPE_CNT_EN
    exp_cnt = (acks > 65535) ? 16'hFFFF : acks[15:0];
`else
    exp_cnt = 16'h0000 + 16'(acks * 0);
`endif
  endfunction

  task automatic idle_inputs();
    valid_in = 1'b0; pc_in = '0; cause_in = '0; exc_in = 1'b0;
    src_req = '0; stall = 1'b0; flush = 1'b0; exc_ack = 1'b0;
  endtask

  // Acknowledge from REQ, check DRAIN, then check return to IDLE.
  task automatic do_ack(input logic [31:0] held_pc);
    idle_inputs();
    exc_ack = 1'b1;
    step();
    n_acks++;
    chk("ack_valid", {31'b0, valid_out}, 32'd0);
    chk("ack_exc_req", {31'b0, exc_req}, 32'd0);
    chk("drain_busy", {31'b0, busy}, 32'd1);
    chk("ack_cause_low", {1'b0, cause_out[30:0]}, 32'd0);
    chk("drain_pc", pc_out, held_pc);
    exc_ack = 1'b0;
    valid_in = 1'b1; pc_in = 32'h5555; src_req = 4'b0001;
    step();
    chk("post_drain_busy", {31'b0, busy}, 32'd0);
    chk("drain_no_capture", pc_out, held_pc);
    chk("drain_no_valid", {31'b0, valid_out}, 32'd0);
    chk("cnt", {16'b0, exc_cnt}, {16'b0, exp_cnt(n_acks)});
    idle_inputs();
  endtask

  initial begin
    reset_n = 1'b0;
    src_code = {5'd12, 5'd10, 5'd4, 5'd5};
    idle_inputs();
    #1;
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_cause", cause_out, 32'd0);
    chk("rst_exc_req", {31'b0, exc_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cnt", {16'b0, exc_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Clean pass
    valid_in = 1'b1; pc_in = 32'h3000;
    step();
    chk("clean_valid", {31'b0, valid_out}, 32'd1);
    chk("clean_pc", pc_out, 32'h3000);
    chk("clean_cause", cause_out, 32'd0);
    chk("clean_exc_req", {31'b0, exc_req}, 32'd0);
    chk("clean_busy", {31'b0, busy}, 32'd0);

    // Priority among local sources: slice 1 (code 4) wins
    valid_in = 1'b1; pc_in = 32'h3004; src_req = 4'b0110;
    step();
    chk("prio_cause", cause_out, 32'h0000_0010);
    chk("prio_exc_req", {31'b0, exc_req}, 32'd1);
    chk("prio_valid", {31'b0, valid_out}, 32'd1);
    chk("prio_busy", {31'b0, busy}, 32'd1);

    // Hold in REQ for 3 cycles; flush/stall and new inputs ignored
    valid_in = 1'b1; pc_in = 32'h9999; src_req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1); stall = (i == 2);
      step();
      chk("hold_exc_req", {31'b0, exc_req}, 32'd1);
      chk("hold_busy", {31'b0, busy}, 32'd1);
      chk("hold_pc", pc_out, 32'h3004);
    end
    do_ack(32'h3004);

    // Upstream exception wins over local source
    valid_in = 1'b1; pc_in = 32'h3008; exc_in = 1'b1;
    cause_in = 32'h8000_0028; src_req = 4'b0001;
    step();
    chk("up_cause", cause_out, 32'h8000_0028);
    chk("up_exc_req", {31'b0, exc_req}, 32'd1);
    do_ack(32'h3008);

    // valid_in low: requests ignored, BD bit still copied
    valid_in = 1'b0; pc_in = 32'h300C; cause_in = 32'h8000_0000;
    src_req = 4'b1111; exc_in = 1'b1; exc_ack = 1'b1;
    step();
    chk("inv_valid", {31'b0, valid_out}, 32'd0);
    chk("inv_cause", cause_out, 32'h8000_0000);
    chk("inv_exc_req", {31'b0, exc_req}, 32'd0);
    chk("idle_ack_busy", {31'b0, busy}, 32'd0);
    idle_inputs();

    // Flush beats stall in IDLE
    valid_in = 1'b1; pc_in = 32'h4000; cause_in = 32'h8000_0000;
    step();
    chk("pre_flush_valid", {31'b0, valid_out}, 32'd1);
    stall = 1'b1; flush = 1'b1; pc_in = 32'h4100;
    step();
    chk("flush_valid", {31'b0, valid_out}, 32'd0);
    chk("flush_cause", cause_out, 32'h8000_0000);
    chk("flush_pc", pc_out, 32'h4000);

    // Stall alone holds everything
    idle_inputs();
    valid_in = 1'b1; pc_in = 32'h4200;
    step();
    stall = 1'b1; pc_in = 32'h4300; src_req = 4'b0001;
    step();
    chk("stall_pc", pc_out, 32'h4200);
    chk("stall_valid", {31'b0, valid_out}, 32'd1);
    chk("stall_exc_req", {31'b0, exc_req}, 32'd0);
    idle_inputs();

    // Third acknowledged exception
    valid_in = 1'b1; pc_in = 32'h5000; src_req = 4'b1000;
    step();
    chk("third_cause", cause_out, 32'h0000_0030);
    do_ack(32'h5000);
    chk("cnt_three", {16'b0, exc_cnt}, {16'b0, exp_cnt(3)});

`ifdef EXC_PIPE_CNT_EN
    // Saturation from a preloaded counter
    force dut.r_exc_cnt = 16'hFFFF;
    #1;
    release dut.r_exc_cnt;
    valid_in = 1'b1; pc_in = 32'h5100; src_req = 4'b0001;
    step();
    idle_inputs();
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    step();
    chk("cnt_sat", {16'b0, exc_cnt}, 32'h0000_FFFF);
`endif

    // Reset while in REQ abandons the exception immediately
    valid_in = 1'b1; pc_in = 32'h6000; src_req = 4'b0001;
    step();
    chk("pre_rst_exc_req", {31'b0, exc_req}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_exc_req", {31'b0, exc_req}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_cnt", {16'b0, exc_cnt}, 32'd0);
    chk("mid_rst_pc", pc_out, 32'd0);
    #2;
    reset_n = 1'b1;
    idle_inputs();
    valid_in = 1'b1; pc_in = 32'h7000;
    step();
    chk("post_rst_capture", pc_out, 32'h7000);
    chk("post_rst_valid", {31'b0, valid_out}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
